// File: rtl/pipeline_skid_ff_if.sv
// rtl/pipeline_skid_ff_if.sv - valid/ready/data beat stream interface for pipeline_skid_ff
//
// Signals:
//   valid  producer -> consumer  beat present
//   data   producer -> consumer  payload, Width bits
//   ready  consumer -> producer  beat accepted when valid && ready at a rising edge
// Modports:
//   master  drives valid/data, observes ready (producer side)
//   slave   observes valid/data, drives ready (consumer side)
interface pipeline_skid_ff_if #(
    parameter int Width = 32
) ();
    logic             valid;
    logic [Width-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_skid_ff.sv
// rtl/pipeline_skid_ff.sv - elastic valid/ready pipeline of Depth registered skid stages
//
// Every stage owns a main register and a skid register. The stage ready is a
// decode of its own state register only, so no combinational path runs from
// out_if.ready back to in_if.ready. Latency is Depth cycles and a stream moves
// at one beat per cycle while the consumer is ready. With the consumer stalled
// the pipe holds 2*Depth beats.
//
// Optional build: define PIPELINE_SKID_FF_STATS_EN to add the occupancy and
// stall_cnt outputs together with the CntWidth parameter.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset; clears all valids
//   flush      in   synchronous clear of all stored beats (wins over handshakes)
//   in_if      slave  producer side: valid, data in; ready out
//   out_if     master consumer side: valid, data out; ready in
//   occupancy  out  beats stored, 0..2*Depth          (stats build only)
//   stall_cnt  out  saturating count of stall cycles  (stats build only)
module pipeline_skid_ff #(
    parameter int Width = 32,
    parameter int Depth = 2
`ifdef PIPELINE_SKID_FF_STATS_EN
    ,
    parameter int CntWidth = 32
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    pipeline_skid_ff_if.slave  in_if,
    pipeline_skid_ff_if.master out_if
`ifdef PIPELINE_SKID_FF_STATS_EN
    ,
    output logic [$clog2(2*Depth+1)-1:0] occupancy,
    output logic [CntWidth-1:0]          stall_cnt
`endif
);

    // Encoding doubles as the number of beats a stage holds.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    // Index k is the link feeding stage k; index Depth is the pipe output.
    logic [Depth:0]   w_vld;
    logic [Depth:0]   w_rdy;
    logic [Width-1:0] w_dat [0:Depth];

    assign w_vld[0]     = in_if.valid;
    assign w_dat[0]     = in_if.data;
    assign in_if.ready  = w_rdy[0];
    assign out_if.valid = w_vld[Depth];
    assign out_if.data  = w_dat[Depth];
    assign w_rdy[Depth] = out_if.ready;

`ifdef PIPELINE_SKID_FF_STATS_EN
    logic [1:0] w_cnt_nxt [0:Depth-1];
`endif

    for (genvar g = 0; g < Depth; g++) begin : g_stage
        stage_state_t     r_state;
        stage_state_t     w_state_nxt;
        logic [Width-1:0] r_m_d;
        logic [Width-1:0] r_s_d;
        logic             w_accept;
        logic             w_down_rdy;
        logic             w_ld_m_in;
        logic             w_ld_m_skid;
        logic             w_ld_s;

        assign w_down_rdy = w_rdy[g+1];
        assign w_accept   = w_vld[g] && (r_state != ST_FULL);

        always_comb begin
            w_state_nxt = r_state;
            w_ld_m_in   = 1'b0;
            w_ld_m_skid = 1'b0;
            w_ld_s      = 1'b0;
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_BUSY;
                        w_ld_m_in   = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_accept && !w_down_rdy) begin
                        // Downstream stalled: park the in-flight beat in the skid.
                        w_state_nxt = ST_FULL;
                        w_ld_s      = 1'b1;
                    end else if (w_accept) begin
                        // Emit and accept together: main reloads, count unchanged.
                        w_ld_m_in   = 1'b1;
                    end else if (w_down_rdy) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_down_rdy) begin
                        w_state_nxt = ST_BUSY;
                        w_ld_m_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
            if (flush) begin
                w_state_nxt = ST_EMPTY;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_EMPTY;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // Payload registers carry no reset; the valids qualify them.
        always_ff @(posedge clk) begin
            if (w_ld_m_in) begin
                r_m_d <= w_dat[g];
            end else if (w_ld_m_skid) begin
                r_m_d <= r_s_d;
            end
            if (w_ld_s) begin
                r_s_d <= w_dat[g];
            end
        end

        assign w_rdy[g]   = (r_state != ST_FULL);
        assign w_vld[g+1] = (r_state != ST_EMPTY);
        assign w_dat[g+1] = r_m_d;

`ifdef PIPELINE_SKID_FF_STATS_EN
        assign w_cnt_nxt[g] = (w_state_nxt == ST_FULL) ? 2'd2 :
                              (w_state_nxt == ST_BUSY) ? 2'd1 : 2'd0;
`endif
    end

`ifdef PIPELINE_SKID_FF_STATS_EN
    localparam int OccWidth = $clog2(2*Depth+1);

    logic [OccWidth-1:0] r_occ;
    logic [OccWidth-1:0] w_occ_nxt;
    logic [CntWidth-1:0] r_stall;

    // Summing next states keeps the registered count equal to the beats held.
    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < Depth; i++) begin
            w_occ_nxt = w_occ_nxt + OccWidth'(w_cnt_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ   <= '0;
            r_stall <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            if (flush) begin
                r_stall <= '0;
            end else if (out_if.valid && !out_if.ready && (r_stall != '1)) begin
                r_stall <= r_stall + CntWidth'(1);
            end
        end
    end

    assign occupancy = r_occ;
    assign stall_cnt = r_stall;
`endif

endmodule
